fpnew_pipe_chain: RTL

FPNEW_PIPE_CHAIN -- requirements
Module: fpnew_pipe_chain

---
 rtl/fpnew_pipe_chain.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fpnew_pipe_chain.sv
// Elastic pipeline of NumPipeRegs valid/ready stages with bubble collapse, flush, tag-selective
// kill and an optional output skid register that cuts the out_ready_i -> in_ready_o path.
module fpnew_pipe_chain #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned TagWidth    = 4,
    parameter int unsigned NumPipeRegs = 2,
    parameter int unsigned SkidBuffer  = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [DataWidth-1:0]                 data_i,
    input  logic [TagWidth-1:0]                  tag_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic                                 flush_i,
    input  logic                                 kill_i,
    input  logic [TagWidth-1:0]                  kill_tag_i,
    output logic [DataWidth-1:0]                 data_o,
    output logic [TagWidth-1:0]                  tag_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [$clog2(NumPipeRegs+2)-1:0]     occupancy_o,
    output logic                                 busy_o
);
    localparam int unsigned OccWidth = $clog2(NumPipeRegs + 2);

    // Index 0 is the input port, index i+1 is the output of stage i.
    logic [NumPipeRegs:0] chain_valid;
    logic [NumPipeRegs:0] chain_ready;
    logic [NumPipeRegs:0] kill_hit;
    logic [DataWidth-1:0] chain_data [NumPipeRegs+1];
    logic [TagWidth-1:0]  chain_tag  [NumPipeRegs+1];
    logic                 last_ready;
    logic                 skid_valid;

    assign chain_valid[0] = in_valid_i;
    assign chain_data[0]  = data_i;
    assign chain_tag[0]   = tag_i;
    assign in_ready_o     = chain_ready[0];

    always_comb begin
        chain_ready[NumPipeRegs] = last_ready;
        for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
            chain_ready[i] = chain_ready[i+1] | ~chain_valid[i+1];
        end
    end

    // The entering item is never a kill target, so kill_hit[0] stays low.
    always_comb begin
        kill_hit = '0;
        for (int i = 1; i <= int'(NumPipeRegs); i++) begin
            kill_hit[i] = kill_i & chain_valid[i] & (chain_tag[i] == kill_tag_i);
        end
    end

    for (genvar i = 0; i < NumPipeRegs; i++) begin : g_stage
        logic                 valid_q;
        logic [DataWidth-1:0] data_q;
        logic [TagWidth-1:0]  tag_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else begin
                if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (chain_ready[i]) begin
                    valid_q <= chain_valid[i] & ~kill_hit[i];
                end else begin
                    valid_q <= valid_q & ~kill_hit[i+1];
                end
                if (chain_ready[i] && chain_valid[i]) begin
                    data_q <= chain_data[i];
                    tag_q  <= chain_tag[i];
                end
            end
        end

        assign chain_valid[i+1] = valid_q;
        assign chain_data[i+1]  = data_q;
        assign chain_tag[i+1]   = tag_q;
    end

    if (SkidBuffer != 0) begin : g_skid
        logic                 valid_q;
        logic [DataWidth-1:0] data_q;
        logic [TagWidth-1:0]  tag_q;
        logic                 skid_kill;
        logic                 capture;

        assign skid_kill = kill_i & valid_q & (tag_q == kill_tag_i);
        assign capture   = ~valid_q & chain_valid[NumPipeRegs] & ~out_ready_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else begin
                if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (valid_q) begin
                    valid_q <= ~out_ready_i & ~skid_kill;
                end else begin
                    valid_q <= capture & ~kill_hit[NumPipeRegs];
                end
                if (capture) begin
                    data_q <= chain_data[NumPipeRegs];
                    tag_q  <= chain_tag[NumPipeRegs];
                end
            end
        end

        assign skid_valid  = valid_q;
        assign last_ready  = ~valid_q;
        assign out_valid_o = valid_q | chain_valid[NumPipeRegs];
        assign data_o      = valid_q ? data_q : chain_data[NumPipeRegs];
        assign tag_o       = valid_q ? tag_q : chain_tag[NumPipeRegs];
    end else begin : g_no_skid
        assign skid_valid  = 1'b0;
        assign last_ready  = out_ready_i;
        assign out_valid_o = chain_valid[NumPipeRegs];
        assign data_o      = chain_data[NumPipeRegs];
        assign tag_o       = chain_tag[NumPipeRegs];
    end

    always_comb begin
        occupancy_o = OccWidth'(skid_valid);
        busy_o      = in_valid_i | skid_valid;
        for (int i = 1; i <= int'(NumPipeRegs); i++) begin
            occupancy_o = occupancy_o + OccWidth'(chain_valid[i]);
            busy_o      = busy_o | chain_valid[i];
        end
    end

    // Purely combinational configurations leave the sequential inputs dangling.
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_ni, flush_i, kill_i, kill_tag_i, kill_hit};

endmodule
